// File: rtl/reg_dump_ctrl.sv
// Streams the 32-entry register file out as a byte stream: header, r0..r31 MSB first,
// then an XOR checksum of the data bytes. Valid/ready handshake with unbounded stalls.
module reg_dump_ctrl #(
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic        cpu_clk_75M,
    input  logic        cpu_rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  debug_addr,
    input  logic [31:0] debug_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StLoad,
        StSend,
        StCsum
    } state_e;

    state_e      state_q;
    logic [4:0]  index_q;
    logic [31:0] shift_q;
    logic [7:0]  csum_q;
    logic [1:0]  cnt_q;
    logic [7:0]  out_data_q;
    logic        out_valid_q;
    logic        busy_q;
    logic        done_q;

    logic        xfer;
    logic [7:0]  csum_d;
    logic [31:0] shift_d;

    assign xfer    = out_valid_q & out_ready;
    assign csum_d  = csum_q ^ shift_q[31:24];
    assign shift_d = {shift_q[23:0], 8'h00};

    assign debug_addr = index_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q     <= StIdle;
            index_q     <= 5'd0;
            shift_q     <= 32'd0;
            csum_q      <= 8'd0;
            cnt_q       <= 2'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Abort wins over any transfer; it is meaningless while idle.
            if (state_q != StIdle && abort) begin
                state_q     <= StIdle;
                out_valid_q <= 1'b0;
                out_data_q  <= 8'd0;
                busy_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_q     <= StHdr;
                            index_q     <= 5'd0;
                            csum_q      <= 8'd0;
                            cnt_q       <= 2'd0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= HDR_BYTE;
                            busy_q      <= 1'b1;
                        end
                    end
                    StHdr: begin
                        if (xfer) begin
                            state_q     <= StLoad;
                            out_valid_q <= 1'b0;
                            out_data_q  <= 8'd0;
                        end
                    end
                    StLoad: begin
                        shift_q     <= debug_data;
                        out_data_q  <= debug_data[31:24];
                        out_valid_q <= 1'b1;
                        state_q     <= StSend;
                    end
                    StSend: begin
                        if (xfer) begin
                            shift_q <= shift_d;
                            csum_q  <= csum_d;
                            cnt_q   <= cnt_q + 2'd1;
                            if (cnt_q == 2'd3) begin
                                if (index_q == 5'd31) begin
                                    state_q    <= StCsum;
                                    out_data_q <= csum_d;
                                end else begin
                                    index_q     <= index_q + 5'd1;
                                    state_q     <= StLoad;
                                    out_valid_q <= 1'b0;
                                    out_data_q  <= 8'd0;
                                end
                            end else begin
                                out_data_q <= shift_q[23:16];
                            end
                        end
                    end
                    StCsum: begin
                        if (xfer) begin
                            state_q     <= StIdle;
                            out_valid_q <= 1'b0;
                            out_data_q  <= 8'd0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                    default: begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Self-checking bench for reg_dump_ctrl: a byte-queue model of the dump stream is compared
// against the DUT on every cycle, with random backpressure, abort, reset and start misuse.
module tb_reg_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b1;
    logic [4:0]  debug_addr;
    logic [31:0] debug_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    assign debug_data = regs[debug_addr];

    reg_dump_ctrl #(.HDR_BYTE(8'hA5)) dut (
        .cpu_clk_75M(clk),
        .cpu_rst_n  (rst_n),
        .start      (start),
        .abort      (abort),
        .debug_addr (debug_addr),
        .debug_data (debug_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int  ptr = 0;
    int  busy_cnt = 0;
    bit  chk_en = 1'b0;
    bit  done_pend = 1'b0;
    bit  done_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected stream straight from the register contents.
    task automatic build_expected();
        logic [7:0] cs;
        logic [7:0] b8;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        cs = 8'h00;
        for (int r = 0; r < 32; r++) begin
            for (int b = 0; b < 4; b++) begin
                b8 = regs[r][31-8*b -: 8];
                exp_q.push_back(b8);
                cs ^= b8;
            end
        end
        exp_q.push_back(cs);
    endtask

    // Compare process: outputs sampled on the falling edge, inputs change at posedge+2.
    always @(negedge clk) begin
        if (chk_en) begin
            bit xfer;
            xfer = out_valid && out_ready && !abort;
            chk("done_pulse", done, done_pend);
            if (done) done_seen = 1'b1;
            if (busy) busy_cnt++;
            if (out_valid) begin
                if (ptr < 130) chk($sformatf("data[%0d]", ptr), out_data, exp_q[ptr]);
                else chk("extra_byte", ptr, 129);
            end
            if (xfer) begin
                got_q.push_back(out_data);
                ptr++;
            end
            done_pend = xfer && (ptr == 130);
        end
    end

    task automatic arm();
        build_expected();
        got_q.delete();
        ptr = 0;
        busy_cnt = 0;
        done_pend = 1'b0;
        done_seen = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic run_dump(input bit bp, input bit mid_start, input bit with_abort);
        arm();
        @(posedge clk); #2;
        start = 1'b1;
        abort = with_abort;
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        abort = 1'b0;
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        chk("hdr_next_cycle", {busy, out_valid, out_data}, {1'b1, 1'b1, 8'hA5});
        for (int c = 0; c < 4000 && !done_seen; c++) begin
            @(posedge clk); #2;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            start = mid_start && (c == 40);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        out_ready = 1'b1;
        chk("done_seen", done_seen, 1);
        chk("byte_count", ptr, 130);
        chk("busy_after", busy, 0);
        if (!bp) chk("busy_cycles", busy_cnt, 162);
    endtask

    task automatic run_abort();
        arm();
        @(posedge clk); #2;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        // Byte 31 is r7 byte 2: wait until bytes 0..30 have gone.
        for (int c = 0; c < 500 && ptr != 31; c++) begin
            @(posedge clk); #2;
        end
        chk("abort_reach_r7b2", ptr, 31);
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", {busy, out_valid}, 2'b00);
        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        chk("abort_no_done", done_seen, 0);
        chk("abort_ptr", ptr, 31);
    endtask

    task automatic run_reset_mid();
        arm();
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (80) @(posedge clk);
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {debug_addr, out_data, out_valid, busy, done}, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_rst", {busy, out_valid, done}, 0);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 32; i++) regs[i] = 32'h01010101 * i;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        #1;
        chk("reset_outputs", {debug_addr, out_data, out_valid, busy, done}, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        fill_ramp();
        run_dump(1'b0, 1'b0, 1'b0);
        if (got_q.size() == 130) begin
            chk("ramp_hdr", got_q[0], 8'hA5);
            chk("ramp_r1b0", got_q[5], 8'h01);
            chk("ramp_r31b3", got_q[128], 8'h1F);
            chk("ramp_csum", got_q[129], 8'h00);
        end

        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'hDEADBEEF;
        run_dump(1'b0, 1'b0, 1'b0);
        if (got_q.size() == 130) begin
            chk("dead_b5", got_q[5], 8'hDE);
            chk("dead_b6", got_q[6], 8'hAD);
            chk("dead_b7", got_q[7], 8'hBE);
            chk("dead_b8", got_q[8], 8'hEF);
            chk("dead_csum", got_q[129], 8'h22);
        end

        fill_ramp();
        run_dump(1'b1, 1'b1, 1'b0);

        run_abort();
        run_dump(1'b0, 1'b0, 1'b0);

        run_reset_mid();
        run_dump(1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        run_dump(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        run_dump(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
